// File: rtl/two_port_mem_model_param.sv
// two_port_mem_model_param: parametrised single-clock true two-port RAM model.
// Optional power-up clear sweep enabled by defining TWO_PORT_MEM_INIT_CLEAR_EN.
module two_port_mem_model_param #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4096,
  parameter int AW     = 12,
  parameter int RD_LAT = 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               CENA,
  input  logic               WENA,
  input  logic [WIDTH/8-1:0] BWENA,
  input  logic [AW-1:0]      AA,
  input  logic [WIDTH-1:0]   DA,
  input  logic               OENA,
  output logic [WIDTH-1:0]   QA,
  input  logic               CENB,
  input  logic               WENB,
  input  logic [WIDTH/8-1:0] BWENB,
  input  logic [AW-1:0]      AB,
  input  logic [WIDTH-1:0]   DB,
  input  logic               OENB,
  output logic [WIDTH-1:0]   QB,
  output logic               COLL,
  output logic               ERR
);

  localparam int NB = WIDTH / 8;
  localparam logic [AW:0] LIM  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
    $error("two_port_mem_model_param: RD_LAT must be 1 or 2");
  end

  if (WIDTH % 8 != 0 || WIDTH < 8) begin : g_bad_width
    $error("two_port_mem_model_param: WIDTH must be a multiple of 8");
  end

  logic ready;
  logic clr_we;
  logic [AW-1:0] clr_addr;

`ifdef TWO_PORT_MEM_INIT_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    READY
  } clr_t;

  clr_t state;
  clr_t state_nx;
  logic clr_last;

  assign clr_last = {1'b0, clr_addr} == LAST;

  // Clear FSM state and sweep address register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      clr_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      else clr_addr <= '0;
    end
  end

  // Sweep every word once, then open the ports
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = CLEAR;
      CLEAR:   if (clr_last) state_nx = READY;
      READY:   state_nx = READY;
      default: state_nx = IDLE;
    endcase
  end

  assign ready  = state == READY;
  assign clr_we = state == CLEAR;
`else
  assign ready    = 1'b1;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  logic in_a;
  logic in_b;
  logic acc_a;
  logic acc_b;
  logic wr_a;
  logic wr_b;
  logic rd_a;
  logic rd_b;

  assign in_a  = {1'b0, AA} < LIM;
  assign in_b  = {1'b0, AB} < LIM;
  assign acc_a = ready && !CENA;
  assign acc_b = ready && !CENB;
  assign wr_a  = acc_a && !WENA && in_a;
  assign wr_b  = acc_b && !WENB && in_b;
  assign rd_a  = acc_a && WENA;
  assign rd_b  = acc_b && WENB;

  logic [WIDTH-1:0] mem [DEPTH];

  // Array writes; A is applied last so it owns overlapping bytes
  always_ff @(posedge CLK) begin
    if (clr_we) mem[clr_addr] <= '0;
    if (wr_b) begin
      for (int i = 0; i < NB; i++) begin
        if (!BWENB[i]) mem[AB][8*i +: 8] <= DB[8*i +: 8];
      end
    end
    if (wr_a) begin
      for (int i = 0; i < NB; i++) begin
        if (!BWENA[i]) mem[AA][8*i +: 8] <= DA[8*i +: 8];
      end
    end
  end

  logic [WIDTH-1:0] s1a;
  logic [WIDTH-1:0] s1b;
  logic [WIDTH-1:0] qra;
  logic [WIDTH-1:0] qrb;

  // First read stage: sample old word, hold when idle or writing
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1a <= '0;
      s1b <= '0;
    end else begin
      if (rd_a) s1a <= in_a ? mem[AA] : '0;
      if (rd_b) s1b <= in_b ? mem[AB] : '0;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] s2a;
    logic [WIDTH-1:0] s2b;

    // Second read stage trails the first by one edge
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        s2a <= '0;
        s2b <= '0;
      end else begin
        s2a <= s1a;
        s2b <= s1b;
      end
    end

    assign qra = s2a;
    assign qrb = s2b;
  end else begin : g_lat1
    assign qra = s1a;
    assign qrb = s1b;
  end

  // Collision and range-error pulses, one cycle after the edge
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      COLL <= 1'b0;
      ERR  <= 1'b0;
    end else begin
      COLL <= wr_a && wr_b && (AA == AB);
      ERR  <= (acc_a && !in_a) || (acc_b && !in_b);
    end
  end

  assign QA = OENA ? '0 : qra;
  assign QB = OENB ? '0 : qrb;

endmodule

// File: tb/tb_two_port_mem_model_param.sv
// tb_two_port_mem_model_param: two instances (RD_LAT 1 and 2), DEPTH 3000.
// Behavioural model plus directed literal checks and random traffic.
module tb_two_port_mem_model_param;
  localparam int W = 32;
  localparam int D = 3000;
  localparam int A = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cena, wena, oena, cenb, wenb, oenb;
  logic [3:0] bwa, bwb;
  logic [A-1:0] aa, ab;
  logic [W-1:0] da, db;
  logic [W-1:0] qa1, qb1, qa2, qb2;
  logic coll1, err1, coll2, err2;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mm [16];
  logic [W-1:0] ra, rb, ra2, rb2;
  logic ecoll, eerr;

  always #5 clk = ~clk;

  two_port_mem_model_param #(.WIDTH(W), .DEPTH(D), .AW(A), .RD_LAT(1)) u1 (
    .CLK(clk), .RSTN(rst_n),
    .CENA(cena), .WENA(wena), .BWENA(bwa), .AA(aa), .DA(da), .OENA(oena), .QA(qa1),
    .CENB(cenb), .WENB(wenb), .BWENB(bwb), .AB(ab), .DB(db), .OENB(oenb), .QB(qb1),
    .COLL(coll1), .ERR(err1)
  );

  two_port_mem_model_param #(.WIDTH(W), .DEPTH(D), .AW(A), .RD_LAT(2)) u2 (
    .CLK(clk), .RSTN(rst_n),
    .CENA(cena), .WENA(wena), .BWENA(bwa), .AA(aa), .DA(da), .OENA(oena), .QA(qa2),
    .CENB(cenb), .WENB(wenb), .BWENB(bwb), .AB(ab), .DB(db), .OENB(oenb), .QB(qb2),
    .COLL(coll2), .ERR(err2)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ra = '0; rb = '0; ra2 = '0; rb2 = '0;
    ecoll = 1'b0; eerr = 1'b0;
  endtask

  task automatic model_edge();
    logic ina, inb, wa, wb;
    logic [W-1:0] na, nb;
    if (!rst_n) return;
    ina = int'(aa) < D;
    inb = int'(ab) < D;
    na = ra;
    nb = rb;
    if (!cena && wena) na = ina ? mm[aa[3:0]] : '0;
    if (!cenb && wenb) nb = inb ? mm[ab[3:0]] : '0;
    ra2 = ra; rb2 = rb;
    ra = na; rb = nb;
    wa = !cena && !wena && ina;
    wb = !cenb && !wenb && inb;
    if (wb) for (int i = 0; i < 4; i++) if (!bwb[i]) mm[ab[3:0]][8*i +: 8] = db[8*i +: 8];
    if (wa) for (int i = 0; i < 4; i++) if (!bwa[i]) mm[aa[3:0]][8*i +: 8] = da[8*i +: 8];
    ecoll = wa && wb && (aa == ab);
    eerr = (!cena && !ina) || (!cenb && !inb);
  endtask

  task automatic check_all();
    logic [W-1:0] ea, eb, ea2, eb2;
    ea  = oena ? '0 : ra;
    eb  = oenb ? '0 : rb;
    ea2 = oena ? '0 : ra2;
    eb2 = oenb ? '0 : rb2;
    if (!$isunknown(ea))  chk("qa_lat1", qa1, ea);
    if (!$isunknown(eb))  chk("qb_lat1", qb1, eb);
    if (!$isunknown(ea2)) chk("qa_lat2", qa2, ea2);
    if (!$isunknown(eb2)) chk("qb_lat2", qb2, eb2);
    chk("coll_lat1", {31'b0, coll1}, {31'b0, ecoll});
    chk("coll_lat2", {31'b0, coll2}, {31'b0, ecoll});
    chk("err_lat1", {31'b0, err1}, {31'b0, eerr});
    chk("err_lat2", {31'b0, err2}, {31'b0, eerr});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    cena = 1'b1; wena = 1'b1; bwa = 4'hF; aa = '0; da = '0; oena = 1'b0;
    cenb = 1'b1; wenb = 1'b1; bwb = 4'hF; ab = '0; db = '0; oenb = 1'b0;
  endtask

  task automatic wr_a(input logic [A-1:0] ad, input logic [W-1:0] d, input logic [3:0] m);
    cena = 1'b0; wena = 1'b0; aa = ad; da = d; bwa = m;
  endtask

  task automatic wr_b(input logic [A-1:0] ad, input logic [W-1:0] d, input logic [3:0] m);
    cenb = 1'b0; wenb = 1'b0; ab = ad; db = d; bwb = m;
  endtask

  task automatic rd_a(input logic [A-1:0] ad);
    cena = 1'b0; wena = 1'b1; aa = ad;
  endtask

  task automatic rd_b(input logic [A-1:0] ad);
    cenb = 1'b0; wenb = 1'b1; ab = ad;
  endtask

  function automatic logic [A-1:0] raddr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return A'(r);
    if (r == 16) return A'(3000);
    if (r == 17) return A'(3001);
    if (r == 18) return A'(4095);
    return A'(4000);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mm[i] = 'x;
    model_reset();
    idle();
    repeat (2) cyc();
    chk("reset_qa1", qa1, 32'h0);
    chk("reset_qb2", qb2, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      idle();
      wr_a(A'(i), $urandom, 4'h0);
      cyc();
    end

    idle(); wr_a(12'd5, 32'hDEADBEEF, 4'h0); cyc();
    idle(); rd_b(12'd5); cyc();
    chk("lat1_read5", qb1, 32'hDEADBEEF);
    idle(); cyc();
    chk("lat2_read5", qb2, 32'hDEADBEEF);

    idle(); wr_a(12'd7, 32'h11223344, 4'h0); cyc();
    idle(); wr_a(12'd7, 32'hAABBCCDD, 4'b1010); cyc();
    idle(); rd_a(12'd7); cyc();
    chk("mask_read7", qa1, 32'h11BB33DD);

    idle(); wr_a(12'd9, 32'hAAAAAAAA, 4'h0); wr_b(12'd9, 32'h55555555, 4'h0); cyc();
    chk("coll_pulse", {31'b0, coll1}, 32'h1);
    idle(); rd_a(12'd9); cyc();
    chk("coll_clear", {31'b0, coll1}, 32'h0);
    chk("coll_word9", qa1, 32'hAAAAAAAA);

    idle(); wr_a(12'd3, 32'h1, 4'h0); cyc();
    idle(); wr_a(12'd3, 32'h2, 4'h0); rd_b(12'd3); cyc();
    chk("rdw_old", qb1, 32'h1);
    idle(); rd_b(12'd3); cyc();
    chk("rdw_new", qb1, 32'h2);

    idle(); rd_a(12'd3000); wr_b(12'd4095, 32'h12345678, 4'h0); cyc();
    chk("oor_qa", qa1, 32'h0);
    chk("oor_err", {31'b0, err1}, 32'h1);
    idle(); cyc();
    chk("oor_err_end", {31'b0, err1}, 32'h0);
    idle(); rd_a(12'd7); cyc();
    idle(); oena = 1'b1; cyc();
    chk("oen_gate", qa1, 32'h0);
    idle(); cyc();
    chk("oen_restore", qa1, 32'h11BB33DD);
    idle(); rd_a(12'd3001); rd_b(12'd4095); cyc();
    chk("oor_both", {31'b0, err2}, 32'h1);
    idle(); cyc();
    chk("oor_both_end", {31'b0, err2}, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      cena = $urandom_range(0, 3) == 0;
      wena = 1'($urandom_range(0, 1));
      bwa  = 4'($urandom);
      aa   = raddr();
      da   = $urandom;
      oena = $urandom_range(0, 7) == 0;
      cenb = $urandom_range(0, 3) == 0;
      wenb = 1'($urandom_range(0, 1));
      bwb  = 4'($urandom);
      ab   = raddr();
      db   = $urandom;
      oenb = $urandom_range(0, 7) == 0;
      cyc();
    end

    idle(); wr_a(12'd5, 32'hCAFEF00D, 4'h0); cyc();
    idle(); rd_a(12'd5); cyc();
    chk("pre_rst_lat1", qa1, 32'hCAFEF00D);
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_qa1", qa1, 32'h0);
    chk("rst_qa2", qa2, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("no_stale_qa2", qa2, 32'h0);
    idle(); rd_a(12'd5); cyc();
    chk("post_rst_read", qa1, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
